// File: rtl/wb_arb_switch_if.sv
// Master-side and slave-side Wishbone signals of the arbitrating switch.
// The switch uses modport sw; bus masters and slaves attach through master/slave.
interface wb_arb_switch_if #(
    parameter int NMASTERS = 2,
    parameter int NSLAVES  = 4
);
    logic [NMASTERS-1:0][31:0] m_addr;
    logic [NMASTERS-1:0][31:0] m_wdata;
    logic [NMASTERS-1:0][3:0]  m_sel;
    logic [NMASTERS-1:0]       m_we;
    logic [NMASTERS-1:0]       m_cyc;
    logic [NMASTERS-1:0]       m_stb;
    logic [NMASTERS-1:0][2:0]  m_cti;
    logic [NMASTERS-1:0][1:0]  m_bte;
    logic [NMASTERS-1:0][31:0] m_rdata;
    logic [NMASTERS-1:0]       m_ack;
    logic [NMASTERS-1:0]       m_err;

    logic [31:0]               s_addr;
    logic [31:0]               s_wdata;
    logic [3:0]                s_sel;
    logic                      s_we;
    logic [2:0]                s_cti;
    logic [1:0]                s_bte;
    logic [NSLAVES-1:0]        s_cyc;
    logic [NSLAVES-1:0]        s_stb;
    logic [NSLAVES-1:0][31:0]  s_rdata;
    logic [NSLAVES-1:0]        s_ack;
    logic [NSLAVES-1:0]        s_err;

    modport sw (
        input  m_addr, m_wdata, m_sel, m_we, m_cyc, m_stb, m_cti, m_bte,
        output m_rdata, m_ack, m_err,
        output s_addr, s_wdata, s_sel, s_we, s_cti, s_bte, s_cyc, s_stb,
        input  s_rdata, s_ack, s_err
    );

    modport master (
        output m_addr, m_wdata, m_sel, m_we, m_cyc, m_stb, m_cti, m_bte,
        input  m_rdata, m_ack, m_err
    );

    modport slave (
        input  s_addr, s_wdata, s_sel, s_we, s_cti, s_bte, s_cyc, s_stb,
        output s_rdata, s_ack, s_err
    );
endinterface

// File: rtl/wb_arb_switch.sv
// Round-robin Wishbone B4 interconnect: N masters, address-decoded slaves,
// decode-error responder and per-transfer watchdog.
module wb_arb_switch #(
    parameter int                    NMASTERS   = 2,
    parameter int                    NSLAVES    = 4,
    parameter logic [NSLAVES*32-1:0] BASE_ADDR  = '0,
    parameter logic [NSLAVES*5-1:0]  ADDR_WIDTH = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arb_switch_if.sw bus
);
    localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic          derr_q, derr_d;
    logic          wderr_q, wderr_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic          busy, cyc_g, stb_g;
    logic [31:0]   addr_g;
    logic          hit;
    logic [SW-1:0] slv_idx;
    logic          slv_ack, slv_err;
    logic [31:0]   slv_rdata;
    logic          fwd_ack, fwd_err;
    logic [GW-1:0] rr_pick;

    wire  [NSLAVES-1:0]        hit_vec;
    wire  [NSLAVES-1:0]        s_cyc_w;
    wire  [NSLAVES-1:0]        s_stb_w;
    wire  [NMASTERS-1:0]       m_ack_w;
    wire  [NMASTERS-1:0]       m_err_w;
    wire  [NMASTERS-1:0][31:0] m_rdata_w;

    assign busy   = (state_q == BUSY);
    assign cyc_g  = bus.m_cyc[grant_q];
    assign stb_g  = bus.m_stb[grant_q];
    assign addr_g = bus.m_addr[grant_q];

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVES; gi++) begin : g_dec
            localparam logic [31:0] BASE = BASE_ADDR[gi*32 +: 32];
            localparam int          W    = int'(ADDR_WIDTH[gi*5 +: 5]);
            localparam logic [31:0] MASK = 32'hFFFF_FFFF << W;
            assign hit_vec[gi] = ((addr_g ^ BASE) & MASK) == 32'd0;
        end
    endgenerate

    // Overlapping windows resolve to the highest-numbered slave.
    always_comb begin
        slv_idx = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (hit_vec[i]) slv_idx = SW'(i);
        end
    end

    assign hit       = |hit_vec;
    assign slv_ack   = hit & bus.s_ack[slv_idx];
    assign slv_err   = hit & bus.s_err[slv_idx];
    assign slv_rdata = hit ? bus.s_rdata[slv_idx] : 32'd0;

    // A slave response landing with the watchdog error is swallowed.
    assign fwd_ack = busy & cyc_g & slv_ack & ~wderr_q & ~derr_q;
    assign fwd_err = busy & cyc_g & (derr_q | wderr_q | (slv_err & ~wderr_q));

    generate
        for (gi = 0; gi < NSLAVES; gi++) begin : g_slv
            logic sel;
            assign sel         = busy & hit & (slv_idx == SW'(gi));
            assign s_cyc_w[gi] = sel & cyc_g;
            assign s_stb_w[gi] = sel & stb_g & ~derr_q & ~wderr_q;
        end
        for (gi = 0; gi < NMASTERS; gi++) begin : g_mst
            logic own;
            assign own           = busy & (grant_q == GW'(gi));
            assign m_ack_w[gi]   = own & fwd_ack;
            assign m_err_w[gi]   = own & fwd_err;
            assign m_rdata_w[gi] = own ? slv_rdata : 32'd0;
        end
    endgenerate

    assign bus.s_cyc   = s_cyc_w;
    assign bus.s_stb   = s_stb_w;
    assign bus.m_ack   = m_ack_w;
    assign bus.m_err   = m_err_w;
    assign bus.m_rdata = m_rdata_w;

    assign bus.s_addr  = busy ? addr_g                   : 32'd0;
    assign bus.s_wdata = busy ? bus.m_wdata[grant_q]     : 32'd0;
    assign bus.s_sel   = busy ? bus.m_sel[grant_q]       : 4'd0;
    assign bus.s_we    = busy & bus.m_we[grant_q];
    assign bus.s_cti   = busy ? bus.m_cti[grant_q]       : 3'd0;
    assign bus.s_bte   = busy ? bus.m_bte[grant_q]       : 2'd0;

    // Scan offsets from far to near so the nearest requester after last_q wins.
    always_comb begin
        rr_pick = last_q;
        for (int k = NMASTERS; k >= 1; k--) begin
            if (bus.m_cyc[(int'(last_q) + k) % NMASTERS])
                rr_pick = GW'((int'(last_q) + k) % NMASTERS);
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        derr_d   = 1'b0;
        wderr_d  = 1'b0;
        wd_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (|bus.m_cyc) begin
                    state_d = BUSY;
                    grant_d = rr_pick;
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    derr_d = stb_g & ~hit & ~derr_q & ~wderr_q;
                    if (fwd_ack | fwd_err) begin
                        wd_cnt_d = '0;
                    end else if (stb_g) begin
                        if (wd_cnt_q == CW'(TIMEOUT)) wderr_d = 1'b1;
                        else wd_cnt_d = wd_cnt_q + 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NMASTERS - 1);
            derr_q   <= 1'b0;
            wderr_q  <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            derr_q   <= derr_d;
            wderr_q  <= wderr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_arb_switch.sv
// Bench for wb_arb_switch: directed bus sequences with a response scoreboard
// that matches every master ack/err against the queued expectation.
module tb_wb_arb_switch;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam logic [NS*32-1:0] BASE = {32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h8000_0000};
    localparam logic [NS*5-1:0]  AW   = {5'd16, 5'd28, 5'd28, 5'd28};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arb_switch_if #(.NMASTERS(NM), .NSLAVES(NS)) bus ();

    wb_arb_switch #(
        .NMASTERS(NM), .NSLAVES(NS), .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .TIMEOUT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        int          mst;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_sel   = '0;
        bus.m_we    = '0;
        bus.m_cyc   = '0;
        bus.m_stb   = '0;
        bus.m_cti   = '0;
        bus.m_bte   = '0;
        bus.s_rdata = '0;
        bus.s_ack   = '0;
        bus.s_err   = '0;
    endtask

    task automatic drive_master(input int m, input logic [31:0] addr, input logic we, input logic [2:0] cti);
        bus.m_addr[m]  = addr;
        bus.m_wdata[m] = ~addr;
        bus.m_sel[m]   = 4'hF;
        bus.m_we[m]    = we;
        bus.m_cti[m]   = cti;
        bus.m_cyc[m]   = 1'b1;
        bus.m_stb[m]   = 1'b1;
    endtask

    task automatic drop_master(input int m);
        bus.m_cyc[m] = 1'b0;
        bus.m_stb[m] = 1'b0;
        bus.m_cti[m] = 3'd0;
    endtask

    // Slave sl acks in the current cycle; the scoreboard expects master m to see it.
    task automatic slave_ack(input int m, input int sl, input logic [31:0] d);
        exp_q.push_back('{mst: m, err: 1'b0, data: d});
        bus.s_ack[sl]   = 1'b1;
        bus.s_rdata[sl] = d;
        #1;
        check($sformatf("other_ack_m%0d", 1 - m), 32'(bus.m_ack[1-m]), 32'd0);
        check($sformatf("other_rdata_m%0d", 1 - m), bus.m_rdata[1-m], 32'd0);
        tick();
        bus.s_ack[sl]   = 1'b0;
        bus.s_rdata[sl] = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < NM; i++) begin
                if (bus.m_ack[i] || bus.m_err[i]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("sb_unexpected_m%0d", i), 32'(bus.m_ack[i] | bus.m_err[i]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn m%0d %s rdata=0x%08h", i, bus.m_err[i] ? "err" : "ack", bus.m_rdata[i]);
                        check("sb_master", 32'(i), 32'(e.mst));
                        check("sb_err", 32'(bus.m_err[i]), 32'(e.err));
                        check("sb_ack", 32'(bus.m_ack[i]), 32'(!e.err));
                        if (!e.err) check("sb_rdata", bus.m_rdata[i], e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
        check("rst_s_stb", 32'(bus.s_stb), 32'd0);
        check("rst_s_addr", bus.s_addr, 32'd0);
        check("rst_m_ack", 32'(bus.m_ack), 32'd0);
        check("rst_m_err", 32'(bus.m_err), 32'd0);
        rst = 1'b0;

        // Simultaneous requests after reset: m0 first, one idle gap, then m1.
        drive_master(0, 32'h4000_0000, 1'b0, 3'b000);
        drive_master(1, 32'h2000_0004, 1'b0, 3'b000);
        #1;
        check("arb_idle_before_grant", 32'(bus.s_cyc), 32'd0);
        tick();
        check("arb_first_m0_stb", 32'(bus.s_stb), 32'h2);
        check("arb_first_m0_addr", bus.s_addr, 32'h4000_0000);
        slave_ack(0, 1, 32'h1111_1111);
        drop_master(0);
        #1;
        check("arb_drop_cyc", 32'(bus.s_cyc), 32'd0);
        tick();
        check("arb_gap_cyc", 32'(bus.s_cyc), 32'd0);
        check("arb_gap_addr", bus.s_addr, 32'd0);
        tick();
        check("arb_m1_stb", 32'(bus.s_stb), 32'h4);
        check("arb_m1_addr", bus.s_addr, 32'h2000_0004);
        slave_ack(1, 2, 32'h2222_2222);
        drop_master(1);
        tick();
        drive_master(0, 32'h4000_0000, 1'b0, 3'b000);
        drive_master(1, 32'h2000_0004, 1'b0, 3'b000);
        tick();
        check("arb_rr_back_m0", bus.s_addr, 32'h4000_0000);
        slave_ack(0, 1, 32'h3333_3333);
        drop_master(0);
        drop_master(1);
        tick();
        tick();

        // Single read from slave 1 with a one-cycle slave response.
        drive_master(0, 32'h4000_0010, 1'b0, 3'b000);
        tick();
        check("rd_s_stb", 32'(bus.s_stb), 32'h2);
        check("rd_s_cyc", 32'(bus.s_cyc), 32'h2);
        check("rd_s_addr", bus.s_addr, 32'h4000_0010);
        check("rd_s_we", 32'(bus.s_we), 32'd0);
        tick();
        slave_ack(0, 1, 32'hDEAD_BEEF);
        drop_master(0);
        tick();
        tick();

        // Unmapped write: one-cycle decode error, no slave selected.
        drive_master(1, 32'h1000_0000, 1'b1, 3'b000);
        tick();
        check("derr_s_cyc", 32'(bus.s_cyc), 32'd0);
        check("derr_s_stb", 32'(bus.s_stb), 32'd0);
        check("derr_s_we", 32'(bus.s_we), 32'd1);
        check("derr_not_yet", 32'(bus.m_err[1]), 32'd0);
        exp_q.push_back('{mst: 1, err: 1'b1, data: 32'd0});
        tick();
        check("derr_err", 32'(bus.m_err[1]), 32'd1);
        tick();
        bus.m_stb[1] = 1'b0;
        #1;
        check("derr_one_cycle", 32'(bus.m_err[1]), 32'd0);
        drop_master(1);
        tick();
        tick();

        // Watchdog: slave 2 never answers; a late ack in the error cycle is dropped.
        drive_master(0, 32'h2000_0008, 1'b0, 3'b000);
        tick();
        check("wd_first_stb", 32'(bus.s_stb), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("wd_wait_err_%0d", i), 32'(bus.m_err[0]), 32'd0);
            check($sformatf("wd_wait_stb_%0d", i), 32'(bus.s_stb), 32'h4);
        end
        exp_q.push_back('{mst: 0, err: 1'b1, data: 32'd0});
        tick();
        bus.s_ack[2] = 1'b1;
        #1;
        check("wd_err", 32'(bus.m_err[0]), 32'd1);
        check("wd_late_ack", 32'(bus.m_ack[0]), 32'd0);
        check("wd_stb_masked", 32'(bus.s_stb), 32'd0);
        tick();
        bus.s_ack[2] = 1'b0;
        drop_master(0);
        tick();
        tick();

        // Four-beat incrementing burst by m0 while m1 waits.
        drive_master(0, 32'h8000_0000, 1'b0, 3'b010);
        tick();
        drive_master(1, 32'h4000_0004, 1'b0, 3'b000);
        for (int b = 0; b < 4; b++) begin
            bus.m_addr[0] = 32'h8000_0000 + 32'(4 * b);
            bus.m_cti[0]  = (b == 3) ? 3'b111 : 3'b010;
            #1;
            check($sformatf("burst_stb_%0d", b), 32'(bus.s_stb), 32'h1);
            check($sformatf("burst_addr_%0d", b), bus.s_addr, 32'h8000_0000 + 32'(4 * b));
            check($sformatf("burst_cti_%0d", b), 32'(bus.s_cti), (b == 3) ? 32'h7 : 32'h2);
            slave_ack(0, 0, 32'hA000_0000 + 32'(b));
        end
        drop_master(0);
        #1;
        check("burst_release_cyc", 32'(bus.s_cyc), 32'd0);
        tick();
        check("burst_gap_cyc", 32'(bus.s_cyc), 32'd0);
        tick();
        check("burst_m1_stb", 32'(bus.s_stb), 32'h2);
        check("burst_m1_addr", bus.s_addr, 32'h4000_0004);

        // Reset in the middle of an m1 burst.
        bus.m_cti[1] = 3'b010;
        slave_ack(1, 1, 32'hBBBB_0000);
        bus.m_addr[1] = 32'h4000_0008;
        drive_master(0, 32'h4000_0020, 1'b0, 3'b000);
        rst = 1'b1;
        bus.s_ack[1]   = 1'b1;
        bus.s_rdata[1] = 32'hCCCC_CCCC;
        #1;
        check("mid_rst_s_cyc", 32'(bus.s_cyc), 32'd0);
        check("mid_rst_s_stb", 32'(bus.s_stb), 32'd0);
        check("mid_rst_s_addr", bus.s_addr, 32'd0);
        check("mid_rst_s_cti", 32'(bus.s_cti), 32'd0);
        check("mid_rst_m_ack", 32'(bus.m_ack), 32'd0);
        check("mid_rst_m_rdata1", bus.m_rdata[1], 32'd0);
        tick();
        bus.s_ack[1]   = 1'b0;
        bus.s_rdata[1] = '0;
        rst = 1'b0;
        #1;
        check("post_rst_idle", 32'(bus.s_cyc), 32'd0);
        tick();
        check("post_rst_m0_first", bus.s_addr, 32'h4000_0020);
        slave_ack(0, 1, 32'hDDDD_0001);
        drop_master(0);
        drop_master(1);
        tick();
        tick();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
